// File: rtl/addsub_pkg.sv
// Shared encodings for the digit-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_RSB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_digit_slice.sv
// DIGIT-wide ripple adder; c_msb is the carry into the top bit (overflow detect).
module addsub_digit_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic c;

  // Bit-serial ripple through the digit, tapping the carry before the top bit.
  always_comb begin
    sum   = '0;
    c_msb = 1'b0;
    c     = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial ADD/ADC/SUB/RSB with N/Z/C/V flags and valid/ready handshake.
// Optional signed saturation when ADDSUB_SAT_EN is defined.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("digit_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           st;
  logic [WIDTH-1:0] wa, wb, s_reg;
  logic             carry;
  logic [KW-1:0]    k;

  logic [DIGIT-1:0] d_sum;
  logic             d_co, d_cmsb;
  logic [WIDTH-1:0] ld_wa, ld_wb, s_fin;
  logic             ld_c, last, v_raw;
  logic [WIDTH+DIGIT-1:0] s_cat;
  logic [WIDTH-1:0] s_next;

  // Operands are pre-shifted each cycle, so the slice always sees the low digit.
  addsub_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .x     (wa[DIGIT-1:0]),
    .y     (wb[DIGIT-1:0]),
    .ci    (carry),
    .sum   (d_sum),
    .co    (d_co),
    .c_msb (d_cmsb)
  );

  assign in_ready = (st == ST_IDLE) || ((st == ST_DONE) && out_ready);
  assign s_cat    = {d_sum, s_reg};
  assign s_next   = s_cat[WIDTH+DIGIT-1:DIGIT];
  assign last     = (k == KW'(NDIG - 1));
  assign v_raw    = d_cmsb ^ d_co;

  // Operand steering: every op reduces to wa + wb + carry.
  always_comb begin
    ld_wa = a;
    ld_wb = b;
    ld_c  = 1'b1;
    case (op)
      OP_ADD: ld_c = 1'b0;
      OP_ADC: ld_c = c_in;
      OP_SUB: ld_wb = ~b;
      OP_RSB: begin ld_wa = b; ld_wb = ~a; end
      default: ld_c = 1'b0;
    endcase
  end

  // Final result, optionally clamped on signed overflow.
  always_comb begin
    s_fin = s_next;
`ifdef ADDSUB_SAT_EN
    if (v_raw)
      s_fin = s_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
  end

  // Control FSM plus datapath registers; outputs are registered on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      wa        <= '0;
      wb        <= '0;
      s_reg     <= '0;
      carry     <= 1'b0;
      k         <= '0;
      out_valid <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (in_valid) begin
            wa    <= ld_wa;
            wb    <= ld_wb;
            carry <= ld_c;
            k     <= '0;
            st    <= ST_RUN;
          end
        end
        ST_RUN: begin
          wa    <= wa >> DIGIT;
          wb    <= wb >> DIGIT;
          carry <= d_co;
          s_reg <= s_next;
          k     <= k + 1'b1;
          if (last) begin
            s         <= s_fin;
            c_out     <= d_co;
            flag_v    <= v_raw;
            flag_n    <= s_fin[WIDTH-1];
            flag_z    <= (s_fin == '0);
            out_valid <= 1'b1;
            st        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            st        <= ST_IDLE;
            if (in_valid) begin
              wa    <= ld_wa;
              wb    <= ld_wb;
              carry <= ld_c;
              k     <= '0;
              st    <= ST_RUN;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench: directed table, handshake/reset sequences, random
// ops vs. an arithmetic reference model, and a WIDTH/DIGIT sweep.
module tb_digit_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, c_in = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [1:0]  op = '0;
  logic        in_ready, out_valid, c_out, flag_n, flag_z, flag_v;
  logic [31:0] s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .c_out(c_out), .flag_n(flag_n),
    .flag_z(flag_z), .flag_v(flag_v)
  );

  // Sweep instances: 8/1, 8/8, 16/4, 64/16
  logic [63:0] sa [4];
  logic [63:0] sb [4];
  logic [1:0]  sop [4];
  logic [3:0]  siv = '0, scin = '0, sor = '0;
  logic [3:0]  sir, sov, sc, sn, sz, sv;
  logic [7:0]  s_w0, s_w1;
  logic [15:0] s_w2;
  logic [63:0] s_w3;
  logic [63:0] ss [4];

  assign ss[0] = {56'd0, s_w0};
  assign ss[1] = {56'd0, s_w1};
  assign ss[2] = {48'd0, s_w2};
  assign ss[3] = s_w3;

  digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) sw0 (
    .clk(clk), .rst_n(rst_n), .in_valid(siv[0]), .in_ready(sir[0]),
    .a(sa[0][7:0]), .b(sb[0][7:0]), .c_in(scin[0]), .op(sop[0]), .out_valid(sov[0]),
    .out_ready(sor[0]), .s(s_w0), .c_out(sc[0]), .flag_n(sn[0]), .flag_z(sz[0]), .flag_v(sv[0]));
  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(siv[1]), .in_ready(sir[1]),
    .a(sa[1][7:0]), .b(sb[1][7:0]), .c_in(scin[1]), .op(sop[1]), .out_valid(sov[1]),
    .out_ready(sor[1]), .s(s_w1), .c_out(sc[1]), .flag_n(sn[1]), .flag_z(sz[1]), .flag_v(sv[1]));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) sw2 (
    .clk(clk), .rst_n(rst_n), .in_valid(siv[2]), .in_ready(sir[2]),
    .a(sa[2][15:0]), .b(sb[2][15:0]), .c_in(scin[2]), .op(sop[2]), .out_valid(sov[2]),
    .out_ready(sor[2]), .s(s_w2), .c_out(sc[2]), .flag_n(sn[2]), .flag_z(sz[2]), .flag_v(sv[2]));
  digit_serial_addsub #(.WIDTH(64), .DIGIT(16)) sw3 (
    .clk(clk), .rst_n(rst_n), .in_valid(siv[3]), .in_ready(sir[3]),
    .a(sa[3]), .b(sb[3]), .c_in(scin[3]), .op(sop[3]), .out_valid(sov[3]),
    .out_ready(sor[3]), .s(s_w3), .c_out(sc[3]), .flag_n(sn[3]), .flag_z(sz[3]), .flag_v(sv[3]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [64:0] mask_of(input int w);
    return (w >= 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
  endfunction

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  task automatic ref_op(input int w, input logic [1:0] o, input logic [63:0] ta, input logic [63:0] tb_,
                        input logic ci, output logic [63:0] rs, output logic rc, output logic rn,
                        output logic rz, output logic rv);
    logic [64:0] m, x, y, full, res;
    logic c0;
    m = mask_of(w);
    x = {1'b0, ta} & m;
    y = {1'b0, tb_} & m;
    c0 = 1'b0;
    case (o)
      2'd0: c0 = 1'b0;
      2'd1: c0 = ci;
      2'd2: begin y = ~{1'b0, tb_} & m; c0 = 1'b1; end
      default: begin x = {1'b0, tb_} & m; y = ~{1'b0, ta} & m; c0 = 1'b1; end
    endcase
    full = x + y + {64'd0, c0};
    rc = full[w];
    res = full & m;
    rv = (x[w-1] == y[w-1]) && (res[w-1] != x[w-1]);
`ifdef ADDSUB_SAT_EN
    if (rv) res = res[w-1] ? (m >> 1) : (65'd1 << (w - 1));
`endif
    rs = res[63:0];
    rn = res[w-1];
    rz = (res == '0);
  endtask

  // One full transaction on the 32-bit DUT; returns outputs and latency.
  task automatic run_main(input logic [1:0] o, input logic [31:0] ta, input logic [31:0] tb_, input logic ci,
                          output logic [31:0] rs, output logic rc, output logic rn, output logic rz,
                          output logic rv, output int lat);
    @(negedge clk);
    a = ta; b = tb_; op = o; c_in = ci; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom); c_in = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    rs = s; rc = c_out; rn = flag_n; rz = flag_z; rv = flag_v;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic check_main(input string nm, input logic [1:0] o, input logic [31:0] ta,
                            input logic [31:0] tb_, input logic ci);
    logic [63:0] es; logic ec, en, ez, ev;
    logic [31:0] rs; logic rc, rn, rz, rv; int lat;
    ref_op(32, o, {32'd0, ta}, {32'd0, tb_}, ci, es, ec, en, ez, ev);
    run_main(o, ta, tb_, ci, rs, rc, rn, rz, rv, lat);
    chk({nm, "_lat"}, 64'(lat), 64'd8);
    chk({nm, "_s"}, {32'd0, rs}, es);
    chk({nm, "_c"}, 64'(rc), 64'(ec));
    chk({nm, "_nzv"}, {61'd0, rn, rz, rv}, {61'd0, en, ez, ev});
  endtask

  task automatic run_sw(input int i, input int w, input int nd, input logic [1:0] o,
                        input logic [63:0] ta, input logic [63:0] tb_, input logic ci);
    logic [63:0] es; logic ec, en, ez, ev; int lat; logic [63:0] m;
    m = mask_of(w)[63:0];
    ref_op(w, o, ta & m, tb_ & m, ci, es, ec, en, ez, ev);
    @(negedge clk);
    sa[i] = ta & m; sb[i] = tb_ & m; sop[i] = o; scin[i] = ci; siv[i] = 1'b1;
    #1;
    chk($sformatf("sw%0d_in_ready", i), 64'(sir[i]), 64'd1);
    @(posedge clk); #1; siv[i] = 1'b0;
    lat = 0;
    while (!sov[i] && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("sw%0d_lat", i), 64'(lat), 64'(nd));
    chk($sformatf("sw%0d_s op%0d", i, o), ss[i], es);
    chk($sformatf("sw%0d_c", i), 64'(sc[i]), 64'(ec));
    chk($sformatf("sw%0d_nzv", i), {61'd0, sn[i], sz[i], sv[i]}, {61'd0, en, ez, ev});
    @(negedge clk); sor[i] = 1'b1;
    @(posedge clk); #1; sor[i] = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        ci;
    logic [31:0] s;
    logic        c, n, z, v;
  } vec_t;

  vec_t vt [8];
  logic [31:0] spec_w [4];
  logic [31:0] hs0, rs;
  logic rc, rn, rz, rv;
  int lat, bad;

  initial begin
    for (int i = 0; i < 4; i++) begin sa[i] = '0; sb[i] = '0; sop[i] = '0; end
    spec_w[0] = 32'h0; spec_w[1] = 32'hFFFF_FFFF; spec_w[2] = 32'h7FFF_FFFF; spec_w[3] = 32'h8000_0000;

    vt[0] = '{"add_1_2",   2'd0, 32'h1,         32'h2,         1'b0, 32'h3,         1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{"sub_eq",    2'd2, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{"rsb_5_3",   2'd3, 32'h5,         32'h3,         1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{"adc_wrap",  2'd1, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ADDSUB_SAT_EN
    vt[4] = '{"add_ovf",   2'd0, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{"sub_ovf",   2'd2, 32'h8000_0000, 32'h1,         1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    vt[4] = '{"add_ovf",   2'd0, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{"sub_ovf",   2'd2, 32'h8000_0000, 32'h1,         1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
    vt[6] = '{"add_ign_ci", 2'd0, 32'h5,        32'h6,         1'b1, 32'hB,         1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{"sub_borrow", 2'd2, 32'h0,        32'h1,         1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s_flags", {27'd0, s, c_out, flag_n, flag_z, flag_v}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_main(vt[i].op, vt[i].a, vt[i].b, vt[i].ci, rs, rc, rn, rz, rv, lat);
      chk({vt[i].nm, "_lat"}, 64'(lat), 64'd8);
      chk({vt[i].nm, "_s"}, {32'd0, rs}, {32'd0, vt[i].s});
      chk({vt[i].nm, "_c"}, 64'(rc), 64'(vt[i].c));
      chk({vt[i].nm, "_nzv"}, {61'd0, rn, rz, rv}, {61'd0, vt[i].n, vt[i].z, vt[i].v});
    end

    // Backpressure hold, then retire + accept on the same edge
    @(negedge clk);
    a = 32'h10; b = 32'h20; op = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("hs_first_lat", 64'(lat), 64'd8);
    hs0 = s;
    chk("hs_first_s", {32'd0, hs0}, 64'h30);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (s !== hs0 || in_ready !== 1'b0 || out_valid !== 1'b1 || flag_z !== 1'b0) bad++;
    end
    chk("hs_hold_stable", 64'(bad), 64'd0);
    a = 32'd100; b = 32'd1; op = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("hs_in_ready_combo", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("hs_retired", 64'(out_valid), 64'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("hs_second_lat", 64'(lat), 64'd8);
    chk("hs_second_s", {32'd0, s}, 64'd99);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset while RUN at k=3
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; op = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_s_flags", {27'd0, s, c_out, flag_n, flag_z, flag_v}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid !== 1'b0) bad++; end
    chk("midrst_no_stale", 64'(bad), 64'd0);
    check_main("post_rst", 2'd3, 32'd7, 32'd20, 1'b0);

    // Random ops vs. reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? spec_w[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? spec_w[$urandom_range(0, 3)] : $urandom;
      check_main("rnd", 2'($urandom_range(0, 3)), ra, rb, 1'($urandom));
    end

    // Parameter sweep
    for (int i = 0; i < 4; i++) begin
      int w, nd;
      w  = (i == 0 || i == 1) ? 8 : (i == 2) ? 16 : 64;
      nd = (i == 0) ? 8 : (i == 1) ? 1 : 4;
      run_sw(i, w, nd, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF >> (64 - w), 64'd1, 1'b0);
      run_sw(i, w, nd, 2'd2, 64'd0, 64'd1, 1'b0);
      for (int j = 0; j < 20; j++)
        run_sw(i, w, nd, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
